// File: rtl/seg_scan.sv
// Four-digit multiplexed seven-segment driver: saturating binary-to-BCD
// conversion once per scan frame, then active-low anode/segment scanning.
module seg_scan #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] num,
  input  logic [3:0]  en,
  output logic [3:0]  an,
  output logic [7:0]  seg,
  output logic [15:0] bcd
);

  localparam int unsigned      CNT_W   = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [1:0]        idx;
  logic              frame_start;
  logic              load, shift_en, done;
  logic [13:0]       bin;
  logic [15:0]       bcd_sr;
  logic [3:0]        iter;
  logic [15:0]       adj;
  logic [29:0]       shift_val;
  logic [13:0]       sat;
  logic [3:0]        digit;

  function automatic logic [7:0] decode(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = 8'hFF;
    endcase
    return s;
  endfunction

  // Scan timing: one digit slot per SCAN_DIV cycles, frame = four slots.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt == CNT_MAX) begin
      cnt <= '0;
      idx <= idx + 2'd1;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign frame_start = (cnt == CNT_MAX) && (idx == 2'd3);

  // Converter FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Converter FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (frame_start)     state_nxt = SHIFT;
      SHIFT:   if (iter == 4'd1)    state_nxt = IDLE;
      default:                      state_nxt = IDLE;
    endcase
  end

  // Converter FSM: control outputs
  always_comb begin
    load     = 1'b0;
    shift_en = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE:  load = frame_start;
      SHIFT: begin
        shift_en = 1'b1;
        done     = (iter == 4'd1);
      end
      default: ;
    endcase
  end

  assign sat = (num > 32'd9999) ? 14'd9999 : num[13:0];

  always_comb begin
    adj = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (bcd_sr[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_sr[4*i +: 4] + 4'd3;
      else                          adj[4*i +: 4] = bcd_sr[4*i +: 4];
    end
    shift_val = {adj, bin} << 1;
  end

  // Double-dabble datapath; bcd is only written once the last shift lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin    <= '0;
      bcd_sr <= '0;
      iter   <= '0;
      bcd    <= '0;
    end else if (load) begin
      bin    <= sat;
      bcd_sr <= '0;
      iter   <= 4'd14;
    end else if (shift_en) begin
      bcd_sr <= shift_val[29:14];
      bin    <= shift_val[13:0];
      iter   <= iter - 4'd1;
      if (done) bcd <= shift_val[29:14];
    end
  end

  assign digit = bcd[{idx, 2'b00} +: 4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an  <= '1;
      seg <= '1;
    end else if (en[idx]) begin
      an  <= ~(4'b0001 << idx);
      seg <= decode(digit);
    end else begin
      an  <= '1;
      seg <= '1;
    end
  end

endmodule

// File: tb/tb_seg_scan.sv
// Directed bench for seg_scan with SCAN_DIV=16; bcd updates are scoreboarded
// in order, display slots are checked at computed edge numbers.
module tb_seg_scan;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] num;
  logic [3:0]  en;
  logic [3:0]  an;
  logic [7:0]  seg;
  logic [15:0] bcd;

  int          errors = 0;
  int          checks = 0;
  int          e = 0;
  bit          mon_en = 1'b0;
  logic [15:0] last_bcd;
  logic [15:0] exp_q[$];

  seg_scan #(.SCAN_DIV(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .num   (num),
    .en    (en),
    .an    (an),
    .seg   (seg),
    .bcd   (bcd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic goto(input int target);
    while (e < target) begin
      @(negedge clk);
      e++;
    end
  endtask

  task automatic chk_disp(input string tag, input logic [3:0] exp_an, input logic [7:0] exp_seg);
    chk({tag, "_an"}, {28'h0, an}, {28'h0, exp_an});
    chk({tag, "_seg"}, {24'h0, seg}, {24'h0, exp_seg});
  endtask

  // Every change of bcd must match the next queued expected value.
  always @(negedge clk) begin
    if (mon_en && (bcd !== last_bcd)) begin
      last_bcd = bcd;
      if (exp_q.size() == 0) chk("bcd_unexpected_update", {16'h0, bcd}, 32'hDEAD_BEEF);
      else                   chk("bcd_update", {16'h0, bcd}, {16'h0, exp_q.pop_front()});
    end
  end

  initial begin
    rst_n = 1'b0;
    num   = 32'd1234;
    en    = 4'b1111;
    @(negedge clk);
    @(negedge clk);
    chk_disp("reset", 4'b1111, 8'hFF);
    chk("reset_bcd", {16'h0, bcd}, 32'h0);
    last_bcd = 16'h0;
    mon_en   = 1'b1;
    exp_q.push_back(16'h1234);
    rst_n = 1'b1;
    e = 0;

    // reset mid-scan: digit 1 slot showing, then immediate blanking
    goto(20);
    chk_disp("pre_reset_d1", 4'b1101, 8'hC0);
    #2 rst_n = 1'b0;
    #1 chk_disp("async_reset", 4'b1111, 8'hFF);
    @(negedge clk);
    rst_n = 1'b1;
    e = 0;

    // basic value 1234, frame_start at edge 64, bcd at 78
    goto(77); chk("bcd_before_first", {16'h0, bcd}, 32'h0);
    goto(78); chk("bcd_first", {16'h0, bcd}, 32'h1234);
    goto(79);  chk_disp("d0_1234", 4'b1110, 8'h99);
    goto(96);  chk_disp("d1_1234", 4'b1101, 8'hB0);
    goto(97);  chk_disp("d2_1234", 4'b1011, 8'hA4);
    goto(113); chk_disp("d3_1234_first", 4'b0111, 8'hF9);
    goto(128); chk_disp("d3_1234_last", 4'b0111, 8'hF9);
    goto(129); chk_disp("d0_1234_wrap", 4'b1110, 8'h99);

    // blanking, captured at 192
    goto(130); num = 32'd7; en = 4'b1011; exp_q.push_back(16'h0007);
    goto(205); chk("bcd_hold_1234", {16'h0, bcd}, 32'h1234);
    goto(206); chk("bcd_7", {16'h0, bcd}, 32'h0007);
    goto(208); chk_disp("d0_7", 4'b1110, 8'hF8);
    goto(209); chk_disp("d1_7", 4'b1101, 8'hC0);
    goto(225); chk_disp("d2_blank", 4'b1111, 8'hFF);
    goto(241); chk_disp("d3_7", 4'b0111, 8'hC0);

    // saturation, captured at 256
    goto(250); num = 32'hFFFF_FFFF; en = 4'b1111; exp_q.push_back(16'h9999);
    goto(270); chk("bcd_sat_max", {16'h0, bcd}, 32'h9999);
    goto(272); chk_disp("d0_sat", 4'b1110, 8'h90);
    goto(280); chk_disp("d1_sat", 4'b1101, 8'h90);
    goto(296); chk_disp("d2_sat", 4'b1011, 8'h90);
    goto(312); chk_disp("d3_sat", 4'b0111, 8'h90);
    goto(313); num = 32'd10000;
    goto(334); chk("bcd_sat_10000", {16'h0, bcd}, 32'h9999);

    // mid-frame change: 5 captured at 384, 42 set during idx=1, captured at 448
    goto(335); num = 32'd5; exp_q.push_back(16'h0005);
    goto(397); chk("bcd_hold_9999", {16'h0, bcd}, 32'h9999);
    goto(398); chk("bcd_5", {16'h0, bcd}, 32'h0005);
    goto(405); num = 32'd42; exp_q.push_back(16'h0042);
    for (int t = 447; t <= 461; t++) begin
      goto(t);
      chk("bcd_hold_5", {16'h0, bcd}, 32'h0005);
    end
    goto(462); chk("bcd_42", {16'h0, bcd}, 32'h0042);

    // reset seven shifts into the conversion started at 512
    goto(519);
    exp_q.push_back(16'h0000);
    #2 rst_n = 1'b0;
    #1 chk_disp("reset_mid_shift", 4'b1111, 8'hFF);
    chk("reset_mid_shift_bcd", {16'h0, bcd}, 32'h0);
    goto(521);
    rst_n = 1'b1;
    e = 0;
    num = 32'd8888;
    exp_q.push_back(16'h8888);
    goto(20); chk("no_stale_write", {16'h0, bcd}, 32'h0);
    goto(77); chk("bcd_before_recapture", {16'h0, bcd}, 32'h0);
    goto(78); chk("bcd_8888", {16'h0, bcd}, 32'h8888);
    goto(79); chk_disp("d0_8888", 4'b1110, 8'h80);
    goto(81);
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
